multicycle_control: RTL and testbench

Multicycle RV32I control unit: a Moore state machine with one Mealy branch term. It decodes the instruction-register fields and, each cycle, drives the datapath multiplexer selects, the write enables and the 4-bit `alu_control` code consumed by the ALU. It closes the loop on the ALU's `zero` flag to resolve conditional branches. It sits between the instruction register and the datapath in the multicycle processor core.

---
 rtl/multicycle_control_if.sv | 32 +++
 rtl/multicycle_control.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction-register fields, ALU zero flag and
// datapath control bundle between the multicycle control unit and datapath.
// master = control unit, slave = datapath / instruction register.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic       reg_write;
  logic [3:0] alu_control;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, imm_src, reg_write, alu_control, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, imm_src, reg_write, alu_control, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multicycle control FSM. Moore outputs decoded from
// the registered state and IR fields; BRANCH pc_write is the single Mealy term
// (combinational from zero). Define ILLEGAL_TRAP_EN to trap unknown opcodes in
// a sticky ILLEGAL state; otherwise unknown opcodes execute as a 2-cycle NOP.
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_BGE  = 4'b1011;
  localparam logic [3:0] ALU_GEU  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_LUI, S_AUIPC
`ifdef ILLEGAL_TRAP_EN
    , S_ILLEGAL
`endif
  } state_t;

  state_t state_q, state_d;

  logic [3:0] funct_alu;
  logic [3:0] branch_alu;
  logic       branch_taken;

  // ALU op for R/I arithmetic and for branch compare, plus the taken condition
  always_comb begin
    funct_alu    = ALU_ADD;
    branch_alu   = ALU_ADD;
    branch_taken = 1'b0;
    case (bus.funct3)
      3'b000: funct_alu = (bus.op == OP_R && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: funct_alu = ALU_SLL;
      3'b010: funct_alu = ALU_SLT;
      3'b011: funct_alu = ALU_SLTU;
      3'b100: funct_alu = ALU_XOR;
      3'b101: funct_alu = bus.funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: funct_alu = ALU_OR;
      default: funct_alu = ALU_AND;
    endcase
    case (bus.funct3)
      3'b000: begin branch_alu = ALU_SUB;  branch_taken = bus.zero;  end
      3'b001: begin branch_alu = ALU_SUB;  branch_taken = !bus.zero; end
      3'b100: begin branch_alu = ALU_SLT;  branch_taken = !bus.zero; end
      3'b101: begin branch_alu = ALU_BGE;  branch_taken = !bus.zero; end
      3'b110: begin branch_alu = ALU_SLTU; branch_taken = !bus.zero; end
      3'b111: begin branch_alu = ALU_GEU;  branch_taken = !bus.zero; end
      default: begin branch_alu = ALU_ADD; branch_taken = 1'b0;      end
    endcase
  end

  // Next-state selection; DECODE dispatches on the opcode
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:     state_d = S_EXECR;
          OP_I:     state_d = S_EXECI;
          OP_BR:    state_d = S_BRANCH;
          OP_JAL:   state_d = S_JAL;
          OP_JALR:  state_d = S_JALR;
          OP_LUI:   state_d = S_LUI;
          OP_AUIPC: state_d = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:  state_d = S_ILLEGAL;
`else
          default:  state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL: state_d = S_ALUWB;
      S_JALR:     state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL:  state_d = S_ILLEGAL;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; reset forces FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Output decode from state and IR fields; reset blanks every output
  always_comb begin
    bus.pc_write    = 1'b0;
    bus.adr_src     = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.result_src  = 2'b00;
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.imm_src     = 3'b000;
    bus.reg_write   = 1'b0;
    bus.alu_control = ALU_ADD;
    bus.illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.ir_write = 1'b1; bus.alu_src_b = 2'b10;
        bus.result_src = 2'b10; bus.pc_write = 1'b1;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b01;
        bus.imm_src = (bus.op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01;
        bus.imm_src = (bus.op == OP_LOAD) ? IMM_I : IMM_S;
      end
      S_MEMREAD:  bus.adr_src = 1'b1;
      S_MEMWB:    begin bus.result_src = 2'b01; bus.reg_write = 1'b1; end
      S_MEMWRITE: begin bus.adr_src = 1'b1; bus.mem_write = 1'b1; end
      S_EXECR: begin
        bus.alu_src_a = 2'b10; bus.alu_control = funct_alu;
      end
      S_EXECI: begin
        bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01;
        bus.imm_src = IMM_I; bus.alu_control = funct_alu;
      end
      S_ALUWB:    bus.reg_write = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a = 2'b10; bus.alu_control = branch_alu;
        bus.pc_write = branch_taken;
      end
      S_JALR: begin
        bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01; bus.imm_src = IMM_I;
      end
      S_JAL: begin
        bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b10; bus.pc_write = 1'b1;
      end
      S_LUI: begin
        bus.alu_src_a = 2'b11; bus.alu_src_b = 2'b01; bus.imm_src = IMM_U;
      end
      S_AUIPC: begin
        bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b01; bus.imm_src = IMM_U;
      end
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL:  bus.illegal = 1'b1;
`endif
      default: ;
    endcase
    if (reset) begin
      bus.pc_write    = 1'b0;
      bus.adr_src     = 1'b0;
      bus.mem_write   = 1'b0;
      bus.ir_write    = 1'b0;
      bus.result_src  = 2'b00;
      bus.alu_src_a   = 2'b00;
      bus.alu_src_b   = 2'b00;
      bus.imm_src     = 3'b000;
      bus.reg_write   = 1'b0;
      bus.alu_control = 4'b0000;
      bus.illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-scenario tests of multicycle_control.
// Output vector layout: {pc_write, adr_src, mem_write, ir_write, result_src,
// alu_src_a, alu_src_b, imm_src, reg_write, alu_control, illegal}.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if bus_if ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {bus_if.pc_write, bus_if.adr_src, bus_if.mem_write, bus_if.ir_write,
                bus_if.result_src, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.imm_src,
                bus_if.reg_write, bus_if.alu_control, bus_if.illegal};

  // Hand-computed expected vectors
  localparam logic [18:0] V_ZERO     = 19'b0_0_0_0_00_00_00_000_0_0000_0;
  localparam logic [18:0] V_FETCH    = 19'b1_0_0_1_10_00_10_000_0_0010_0;
  localparam logic [18:0] V_DEC_B    = 19'b0_0_0_0_00_01_01_010_0_0010_0;
  localparam logic [18:0] V_DEC_J    = 19'b0_0_0_0_00_01_01_011_0_0010_0;
  localparam logic [18:0] V_EXECR_SB = 19'b0_0_0_0_00_10_00_000_0_0110_0;
  localparam logic [18:0] V_EXECI_SR = 19'b0_0_0_0_00_10_01_000_0_0011_0;
  localparam logic [18:0] V_ALUWB    = 19'b0_0_0_0_00_00_00_000_1_0010_0;
  localparam logic [18:0] V_MEMADR_L = 19'b0_0_0_0_00_10_01_000_0_0010_0;
  localparam logic [18:0] V_MEMADR_S = 19'b0_0_0_0_00_10_01_001_0_0010_0;
  localparam logic [18:0] V_MEMREAD  = 19'b0_1_0_0_00_00_00_000_0_0010_0;
  localparam logic [18:0] V_MEMWB    = 19'b0_0_0_0_01_00_00_000_1_0010_0;
  localparam logic [18:0] V_MEMWRITE = 19'b0_1_1_0_00_00_00_000_0_0010_0;
  localparam logic [18:0] V_JALR     = 19'b0_0_0_0_00_10_01_000_0_0010_0;
  localparam logic [18:0] V_JAL      = 19'b1_0_0_0_00_01_10_000_0_0010_0;
  localparam logic [18:0] V_LUI      = 19'b0_0_0_0_00_11_01_100_0_0010_0;
  localparam logic [18:0] V_AUIPC    = 19'b0_0_0_0_00_01_01_100_0_0010_0;
  localparam logic [18:0] V_ILLEGAL  = 19'b0_0_0_0_00_00_00_000_0_0010_1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    bus_if.op = op; bus_if.funct3 = f3; bus_if.funct7b5 = f7; bus_if.zero = z;
    #1;
  endtask

  task automatic test_reset();
    set_ir(7'b0110011, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== V_ZERO) begin
        errors++; $display("FAIL reset_cyc%0d: got %b expected %b", i, obs, V_ZERO);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== V_FETCH) begin
      errors++; $display("FAIL reset_first_fetch: got %b expected %b", obs, V_FETCH);
    end
    $display("reset: 3 cycles held, first FETCH after release");
  endtask

  task automatic test_rtype();
    logic [18:0] exp [5];
    exp = '{V_FETCH, V_DEC_B, V_EXECR_SB, V_ALUWB, V_FETCH};
    set_ir(7'b0110011, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL rtype_sub_cyc%0d: got %b expected %b", i, obs, exp[i]);
      end
      if (i < 4) step();
    end
    $display("rtype: sub, FETCH recurs at cycle 5");
  endtask

  task automatic test_itype();
    logic [18:0] exp [5];
    exp = '{V_FETCH, V_DEC_B, V_EXECI_SR, V_ALUWB, V_FETCH};
    set_ir(7'b0010011, 3'b101, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL itype_srai_cyc%0d: got %b expected %b", i, obs, exp[i]);
      end
      if (i < 4) step();
    end
    $display("itype: srai");
  endtask

  task automatic test_load();
    logic [18:0] exp [6];
    exp = '{V_FETCH, V_DEC_B, V_MEMADR_L, V_MEMREAD, V_MEMWB, V_FETCH};
    set_ir(7'b0000011, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL load_cyc%0d: got %b expected %b", i, obs, exp[i]);
      end
      if (i < 5) step();
    end
    $display("load: 5-cycle sequence");
  endtask

  task automatic test_store();
    logic [18:0] exp [5];
    exp = '{V_FETCH, V_DEC_B, V_MEMADR_S, V_MEMWRITE, V_FETCH};
    set_ir(7'b0100011, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL store_cyc%0d: got %b expected %b", i, obs, exp[i]);
      end
      if (i < 4) step();
    end
    $display("store: 4-cycle sequence");
  endtask

  task automatic test_branch();
    logic [2:0]  f3  [6];
    logic        zf  [6];
    logic [18:0] exp [6];
    f3  = '{3'b000, 3'b000, 3'b111, 3'b100, 3'b010, 3'b001};
    zf  = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1};
    exp = '{19'b1_0_0_0_00_10_00_000_0_0110_0,   // BEQ taken
            19'b0_0_0_0_00_10_00_000_0_0110_0,   // BEQ not taken
            19'b1_0_0_0_00_10_00_000_0_1101_0,   // BGEU taken
            19'b0_0_0_0_00_10_00_000_0_0111_0,   // BLT not taken
            19'b0_0_0_0_00_10_00_000_0_0010_0,   // funct3 010: never taken
            19'b0_0_0_0_00_10_00_000_0_0110_0};  // BNE not taken
    for (int t = 0; t < 6; t++) begin
      set_ir(7'b1100011, f3[t], 1'b0, zf[t]);
      checks++;
      if (obs !== V_FETCH) begin
        errors++; $display("FAIL branch%0d_fetch: got %b expected %b", t, obs, V_FETCH);
      end
      step();
      checks++;
      if (obs !== V_DEC_B) begin
        errors++; $display("FAIL branch%0d_decode: got %b expected %b", t, obs, V_DEC_B);
      end
      step();
      checks++;
      if (obs !== exp[t]) begin
        errors++; $display("FAIL branch%0d_exec: got %b expected %b", t, obs, exp[t]);
      end
      step();
      $display("branch: funct3=%b zero=%b pc_write=%b", f3[t], zf[t], exp[t][18]);
    end
    checks++;
    if (obs !== V_FETCH) begin
      errors++; $display("FAIL branch_end_fetch: got %b expected %b", obs, V_FETCH);
    end
  endtask

  task automatic test_jumps();
    logic [18:0] exp_jalr [6];
    logic [18:0] exp_jal  [5];
    exp_jalr = '{V_FETCH, V_DEC_B, V_JALR, V_JAL, V_ALUWB, V_FETCH};
    exp_jal  = '{V_FETCH, V_DEC_J, V_JAL, V_ALUWB, V_FETCH};
    set_ir(7'b1100111, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs !== exp_jalr[i]) begin
        errors++; $display("FAIL jalr_cyc%0d: got %b expected %b", i, obs, exp_jalr[i]);
      end
      if (i < 5) step();
    end
    $display("jalr: 5-cycle sequence");
    set_ir(7'b1101111, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== exp_jal[i]) begin
        errors++; $display("FAIL jal_cyc%0d: got %b expected %b", i, obs, exp_jal[i]);
      end
      if (i < 4) step();
    end
    $display("jal: 4-cycle sequence");
  endtask

  task automatic test_upper();
    logic [6:0]  ops [2];
    logic [18:0] mid [2];
    ops = '{7'b0110111, 7'b0010111};
    mid = '{V_LUI, V_AUIPC};
    for (int t = 0; t < 2; t++) begin
      set_ir(ops[t], 3'b000, 1'b0, 1'b0);
      step();
      checks++;
      if (obs !== V_DEC_B) begin
        errors++; $display("FAIL upper%0d_decode: got %b expected %b", t, obs, V_DEC_B);
      end
      step();
      checks++;
      if (obs !== mid[t]) begin
        errors++; $display("FAIL upper%0d_exec: got %b expected %b", t, obs, mid[t]);
      end
      step();
      checks++;
      if (obs !== V_ALUWB) begin
        errors++; $display("FAIL upper%0d_wb: got %b expected %b", t, obs, V_ALUWB);
      end
      step();
      $display("upper: op=%b", ops[t]);
    end
  endtask

  task automatic test_abort();
    set_ir(7'b0110011, 3'b000, 1'b1, 1'b0);
    step();
    step();
    checks++;
    if (obs !== V_EXECR_SB) begin
      errors++; $display("FAIL abort_execr: got %b expected %b", obs, V_EXECR_SB);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== V_ZERO) begin
      errors++; $display("FAIL abort_reset_outputs: got %b expected %b", obs, V_ZERO);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== V_FETCH) begin
      errors++; $display("FAIL abort_refetch: got %b expected %b", obs, V_FETCH);
    end
    $display("abort: reset mid-instruction returns to FETCH");
  endtask

  task automatic test_illegal();
    set_ir(7'b1111111, 3'b000, 1'b0, 1'b0);
    step();
    checks++;
    if (obs !== V_DEC_B) begin
      errors++; $display("FAIL illegal_decode: got %b expected %b", obs, V_DEC_B);
    end
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (obs !== V_ILLEGAL) begin
        errors++; $display("FAIL illegal_hold%0d: got %b expected %b", i, obs, V_ILLEGAL);
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== V_FETCH) begin
      errors++; $display("FAIL illegal_exit: got %b expected %b", obs, V_FETCH);
    end
    $display("illegal: trapped 10 cycles, cleared by reset");
`else
    step();
    checks++;
    if (obs !== V_FETCH) begin
      errors++; $display("FAIL illegal_nop: got %b expected %b", obs, V_FETCH);
    end
    $display("illegal: 2-cycle NOP");
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load();
    test_store();
    test_branch();
    test_jumps();
    test_upper();
    test_abort();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
